// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 4-bit datapath: fetches from a synchronous ROM,
// sequences the external ALU, writes back to a 4x4 register file and handles jumps.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_en high, imem_addr = pc
// DECODE | ROM word valid, latched into ir, ALU operands set up
// EXEC   | ALU driven, result and flags sampled
// WB     | register/flag/pc commit, OUT pulse
// HALT   | stopped until rst
module alu_sequencer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               alu_s0,
  output logic               alu_s1,
  output logic               alu_cin,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  input  logic [3:0]         alu_g,
  input  logic               alu_cout,
  input  logic               alu_z,
  input  logic               alu_n,
  output logic [3:0]         out_data,
  output logic               out_valid,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c,
  output logic               busy,
  output logic               halted
);

  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JN   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [3:0]        r [4];
  logic [3:0]        ir_op;
  logic [1:0]        ir_ra;
  logic [3:0]        ir_imm;
  logic [3:0]        res;
  logic              tmp_z;
  logic              tmp_n;
  logic              tmp_c;

  logic [3:0]        dec_op;
  logic [1:0]        dec_ra;
  logic [1:0]        dec_rb;
  logic [3:0]        dec_imm;
  logic [PC_W-1:0]   next_pc;

  assign dec_op  = imem_data[11:8];
  assign dec_ra  = imem_data[7:6];
  assign dec_rb  = imem_data[5:4];
  assign dec_imm = imem_data[3:0];

  // Jump targets are the zero-extended immediate; HALT parks pc on itself.
  always_comb begin
    next_pc = pc + PC_W'(1);
    case (ir_op)
      OP_JMP:  next_pc = PC_W'(ir_imm);
      OP_JZ:   if (flag_z) next_pc = PC_W'(ir_imm);
      OP_JN:   if (flag_n) next_pc = PC_W'(ir_imm);
      OP_HALT: next_pc = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      for (int i = 0; i < 4; i++) r[i] <= 4'd0;
      ir_op     <= 4'd0;
      ir_ra     <= 2'd0;
      ir_imm    <= 4'd0;
      res       <= 4'd0;
      tmp_z     <= 1'b0;
      tmp_n     <= 1'b0;
      tmp_c     <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      out_data  <= 4'd0;
      out_valid <= 1'b0;
      imem_en   <= 1'b0;
      imem_addr <= '0;
      alu_s0    <= 1'b0;
      alu_s1    <= 1'b0;
      alu_cin   <= 1'b0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            imem_en   <= 1'b1;
            imem_addr <= pc;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          imem_en <= 1'b0;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          ir_op  <= dec_op;
          ir_ra  <= dec_ra;
          ir_imm <= dec_imm;
          // ALU select bits are the low opcode bits; non-ALU ops leave the ALU at 0.
          if (!dec_op[3]) begin
            {alu_s1, alu_s0, alu_cin} <= dec_op[2:0];
            alu_a <= r[dec_ra];
            alu_b <= r[dec_rb];
          end
          state <= S_EXEC;
        end
        S_EXEC: begin
          res   <= alu_g;
          tmp_z <= alu_z;
          tmp_n <= alu_n;
          tmp_c <= alu_cout;
          {alu_s1, alu_s0, alu_cin} <= 3'b000;
          alu_a <= 4'd0;
          alu_b <= 4'd0;
          if (ir_op == OP_OUT) begin
            out_data  <= r[ir_ra];
            out_valid <= 1'b1;
          end
          state <= S_WB;
        end
        S_WB: begin
          if (!ir_op[3]) begin
            r[ir_ra] <= res;
            flag_z   <= tmp_z;
            flag_n   <= tmp_n;
            if (ir_op == OP_ADD) flag_c <= tmp_c;
          end else if (ir_op == OP_LDI) begin
            r[ir_ra] <= ir_imm;
          end
          pc <= next_pc;
          if (ir_op == OP_HALT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state     <= S_FETCH;
            imem_en   <= 1'b1;
            imem_addr <= next_pc;
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM + ALU models around the DUT, ISA-level reference
// interpreter, directed programs and random programs.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_en;
  logic [3:0]  imem_addr;
  logic [11:0] imem_data;
  logic        alu_s0, alu_s1, alu_cin;
  logic [3:0]  alu_a, alu_b, alu_g;
  logic        alu_cout, alu_z, alu_n;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        flag_z, flag_n, flag_c;
  logic        busy, halted;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(4), .INSTR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_cin(alu_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_g(alu_g),
    .alu_cout(alu_cout), .alu_z(alu_z), .alu_n(alu_n),
    .out_data(out_data), .out_valid(out_valid),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .busy(busy), .halted(halted)
  );

  // synchronous ROM
  logic [11:0] rom [16];
  always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

  // external 4-bit ALU
  logic [4:0] alu_t;
  always_comb begin
    case ({alu_s1, alu_s0, alu_cin})
      3'd0:    alu_t = {1'b0, alu_a};
      3'd1:    alu_t = {1'b0, alu_a} + 5'd1;
      3'd2:    alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd3:    alu_t = {alu_a, 1'b0};
      3'd4:    alu_t = {2'b00, alu_a[3:1]};
      3'd5:    alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'd6:    alu_t = {1'b0, alu_a} + 5'h0F;
      default: alu_t = 5'd0;
    endcase
  end
  assign alu_g    = alu_t[3:0];
  assign alu_cout = alu_t[4];
  assign alu_z    = (alu_t[3:0] == 4'd0);
  assign alu_n    = alu_t[3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ins(input int op, input int ra, input int rb, input int imm);
    ins = 12'((op << 8) | (ra << 6) | (rb << 4) | imm);
  endfunction

  // reference interpreter state
  int m_r [4];
  int m_pc, m_z, m_n, m_c, m_halted;
  int exp_addr [$];
  int exp_alu  [$];
  int exp_out  [$];
  int op6_cnt;

  task automatic model_run(input int max_instr);
    logic [11:0] w;
    int op, ra, rb, imm, a, b, res;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0; m_z = 0; m_n = 0; m_c = 0; m_halted = 0;
    exp_addr.delete(); exp_alu.delete(); exp_out.delete();
    for (int step = 0; step <= max_instr; step++) begin
      exp_addr.push_back(m_pc);
      if (step == max_instr) break;
      w   = rom[m_pc];
      op  = int'(w[11:8]);
      ra  = int'(w[7:6]);
      rb  = int'(w[5:4]);
      imm = int'(w[3:0]);
      a   = m_r[ra];
      b   = m_r[rb];
      if (op < 8) begin
        exp_alu.push_back((op << 8) | (a << 4) | b);
        case (op)
          0: res = a;
          1: res = (a + 1) % 16;
          2: res = (a + b) % 16;
          3: res = (a * 2) % 16;
          4: res = a / 2;
          5: res = (a - b + 16) % 16;
          6: res = (a + 15) % 16;
          default: res = 0;
        endcase
        m_r[ra] = res;
        m_z = (res == 0);
        m_n = (res >= 8);
        if (op == 2) m_c = ((a + b) > 15);
        m_pc = (m_pc + 1) % 16;
      end else begin
        exp_alu.push_back(0);
        case (op)
          8:  begin m_r[ra] = imm; m_pc = (m_pc + 1) % 16; end
          9:  m_pc = imm;
          10: m_pc = m_z ? imm : (m_pc + 1) % 16;
          11: m_pc = m_n ? imm : (m_pc + 1) % 16;
          12: begin exp_out.push_back(m_r[ra]); m_pc = (m_pc + 1) % 16; end
          15: m_halted = 1;
          default: m_pc = (m_pc + 1) % 16;
        endcase
        if (m_halted) break;
      end
    end
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int fetch_i, last_fetch, sig;
    int got_out [$];
    bit done;
    model_run(max_instr);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    fetch_i = 0; last_fetch = -100; done = 0; op6_cnt = 0;
    for (int cyc = 0; cyc < 4 * max_instr + 40 && !done; cyc++) begin
      @(negedge clk);
      if (out_valid) got_out.push_back(int'(out_data));
      if (cyc == last_fetch + 2) begin
        sig = int'({alu_s1, alu_s0, alu_cin, alu_a, alu_b});
        if (fetch_i - 1 < exp_alu.size()) chk({name, ":alu"}, sig, exp_alu[fetch_i-1]);
        if ({alu_s1, alu_s0, alu_cin} == 3'd6) op6_cnt++;
      end
      if (halted) begin
        done = 1;
        chk({name, ":halt_lat"}, cyc - last_fetch, 4);
        chk({name, ":halt_busy"}, int'(busy), 0);
      end else if (imem_en) begin
        if (fetch_i > 0) chk({name, ":spacing"}, cyc - last_fetch, 4);
        if (fetch_i < exp_addr.size()) chk({name, ":addr"}, int'(imem_addr), exp_addr[fetch_i]);
        else chk({name, ":extra_fetch"}, fetch_i, exp_addr.size() - 1);
        chk({name, ":busy"}, int'(busy), 1);
        last_fetch = cyc;
        fetch_i++;
        if (fetch_i == max_instr + 1) done = 1;
      end
    end
    if (!done) chk({name, ":timeout"}, 0, 1);
    chk({name, ":halted"}, int'(halted), m_halted);
    if (m_halted) begin
      repeat (3) begin
        @(negedge clk);
        chk({name, ":halt_hold"}, int'({halted, imem_en, out_valid}), 4);
      end
    end
    for (int i = 0; i < 4; i++) chk({name, ":reg"}, int'(dut.r[i]), m_r[i]);
    chk({name, ":pc"}, int'(dut.pc), m_pc);
    chk({name, ":flag_z"}, int'(flag_z), m_z);
    chk({name, ":flag_n"}, int'(flag_n), m_n);
    chk({name, ":flag_c"}, int'(flag_c), m_c);
    chk({name, ":out_cnt"}, got_out.size(), exp_out.size());
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++)
      chk({name, ":out_data"}, got_out[i], exp_out[i]);
    start = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) rom[i] = 12'hF00;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    fill_halt();

    // reset / idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle:busy_en", int'({busy, imem_en, halted, out_valid}), 0);
      chk("idle:alu", int'({alu_s1, alu_s0, alu_cin, alu_a, alu_b}), 0);
    end
    chk("idle:pc", int'(dut.pc), 0);
    for (int i = 0; i < 4; i++) chk("idle:reg", int'(dut.r[i]), 0);
    chk("idle:out", int'(out_data), 0);

    // LDI / OUT
    fill_halt();
    rom[0] = ins(8, 0, 0, 5); rom[1] = ins(12, 0, 0, 0);
    run_prog("ldi_out", 30);

    // add with carry
    fill_halt();
    rom[0] = ins(8, 0, 0, 9); rom[1] = ins(8, 1, 0, 12); rom[2] = ins(2, 0, 1, 0);
    run_prog("add", 30);
    chk("add:r0", int'(dut.r[0]), 5);
    chk("add:c", int'(flag_c), 1);

    // loop / branch
    fill_halt();
    rom[0] = ins(8, 0, 0, 3); rom[1] = ins(6, 0, 0, 0);
    rom[2] = ins(10, 0, 0, 4); rom[3] = ins(9, 0, 0, 1);
    run_prog("loop", 30);
    chk("loop:dec_cnt", op6_cnt, 3);

    // subtract negative
    fill_halt();
    rom[0] = ins(8, 0, 0, 2); rom[1] = ins(8, 1, 0, 5);
    rom[2] = ins(5, 0, 1, 0); rom[3] = ins(11, 0, 0, 7);
    rom[4] = ins(8, 2, 0, 1);
    run_prog("sub", 30);
    chk("sub:pc", int'(dut.pc), 7);

    // mid-instruction reset during EXEC of ADD
    fill_halt();
    rom[0] = ins(8, 0, 0, 9); rom[1] = ins(8, 1, 0, 12); rom[2] = ins(2, 0, 1, 0);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      @(negedge clk);
      if (imem_en) n++;
    end
    chk("midrst:fetches", n, 3);
    repeat (2) @(negedge clk);
    chk("midrst:exec_sel", int'({alu_s1, alu_s0, alu_cin}), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst:ctrl", int'({busy, imem_en, out_valid, halted, flag_c}), 0);
    chk("midrst:pc", int'(dut.pc), 0);
    for (int i = 0; i < 4; i++) chk("midrst:reg", int'(dut.r[i]), 0);
    rst = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 10 && n == 0; cyc++) begin
      @(negedge clk);
      if (imem_en) begin
        n = 1;
        chk("midrst:refetch", int'(imem_addr), 0);
      end
    end
    chk("midrst:refetch_seen", n, 1);
    start = 1'b0;

    // random programs
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) rom[i] = 12'($urandom_range(0, 4095));
      run_prog("rnd", 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
